fifo_rd_ctrl: RTL and testbench

//  Read-domain controller of the async FIFO, second generation.
//  - Keeps the read pointer as binary and Gray, and drives the RAM read address.
//  - Decodes the synchronised write pointer to compute read-side occupancy.
//  - Drives registered empty / almost-empty flags and a sticky underflow flag.
//  - Optionally adds a first-word-fall-through (FWFT) output stage.
//  - Sits between the 2-flop write-pointer synchroniser and the dual-port RAM read port.

---
 rtl/pkg_graybin.sv | 27 ++
 rtl/fifo_fwft_stage.sv | 53 +++++
 rtl/fifo_rd_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pkg_graybin.sv
// rtl/pkg_graybin.sv - Gray/binary pointer helpers shared by the FIFO read controller
// Purpose : default FIFO depth, pointer/address typedefs and the b2g / g2b
//           conversions. The conversions work on a 32-bit zero-extended value,
//           so any pointer up to 32 bits can be cast in and truncated out.
// Ports   : none (package)
package pkg_graybin;

  localparam int DEPTH = 16;

  typedef logic [$clog2(DEPTH):0]   ptr_t;
  typedef logic [$clog2(DEPTH)-1:0] addr_t;

  function automatic logic [31:0] b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_fwft_stage.sv
// rtl/fifo_fwft_stage.sv - first-word-fall-through output register for the FIFO read side
// Purpose : holds one word in front of the RAM so the consumer sees data
//           without asking for it first.
// Ports   : clk, rst          clock and synchronous active-high reset
//           load              RAM pop this cycle, capture din
//           consume           consumer read request
//           din               RAM read data
//           dout/dout_valid   held word and its valid flag
//           valid_next        dout_valid value after this edge
module fifo_fwft_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             consume,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             valid_next
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  // A load always wins: it refills the register in the same cycle the
  // consumer drains it, so back-to-back reads stream without bubbles.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (load) begin
      dout_d       = din;
      dout_valid_d = 1'b1;
    end else if (consume) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign valid_next = dout_valid_d;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-domain controller of the async FIFO
// Purpose : read pointer (binary + Gray), RAM read address, registered
//           occupancy / empty / almost-empty flags and sticky underflow.
//           Define FIFO_RD_FWFT_EN to add the first-word-fall-through stage.
// Ports   : rclk, rrst        read clock, synchronous active-high reset
//           rden              consumer read request
//           q2_wptr           synchronised Gray write pointer
//           mem_rdata         RAM data at raddr (combinational read)
//           rdptr             registered Gray read pointer to the write side
//           raddr             RAM read address
//           rd_empty, rd_almost_empty, rd_count, rd_underflow   status
//           dout, dout_valid  consumer data
module fifo_rd_ctrl #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  parameter  int AE_TH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rden,
  input  logic [AW:0]      q2_wptr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [AW:0]      rdptr,
  output logic [AW-1:0]    raddr,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic [AW:0]      rd_count,
  output logic             rd_underflow,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  import pkg_graybin::*;

  localparam logic [AW:0] AE_TH_W = (AW+1)'(AE_TH);

  logic [AW:0] rbin_q, rbin_d;
  logic [AW:0] rdptr_q, rdptr_d;
  logic        ram_empty_q, ram_empty_d;
  logic        rd_almost_empty_q, rd_almost_empty_d;
  logic [AW:0] rd_count_q, rd_count_d;
  logic        rd_underflow_q, rd_underflow_d;

  logic [AW:0] wbin;
  logic [AW:0] ram_cnt;
  logic        ram_pop;
  logic        rd_reject;
  logic        held_next;

`ifdef FIFO_RD_FWFT_EN
  logic fwft_valid;

  // Prefetch whenever the output register is empty or being drained.
  assign ram_pop   = !ram_empty_q & (!fwft_valid | rden);
  assign rd_reject = rden & !fwft_valid;
  assign rd_empty  = !fwft_valid;
  assign dout_valid = fwft_valid;

  fifo_fwft_stage #(
    .WIDTH(WIDTH)
  ) u_fwft_stage (
    .clk        (rclk),
    .rst        (rrst),
    .load       (ram_pop),
    .consume    (rden),
    .din        (mem_rdata),
    .dout       (dout),
    .dout_valid (fwft_valid),
    .valid_next (held_next)
  );
`else
  assign ram_pop    = rden & !ram_empty_q;
  assign rd_reject  = rden & ram_empty_q;
  assign rd_empty   = ram_empty_q;
  assign dout       = mem_rdata;
  assign dout_valid = !ram_empty_q;
  assign held_next  = 1'b0;
`endif

  always_comb begin
    wbin    = (AW+1)'(g2b(32'(q2_wptr)));
    rbin_d  = rbin_q + (AW+1)'(ram_pop);
    rdptr_d = (AW+1)'(b2g(32'(rbin_d)));
    // Modulo subtraction is exact because the write side never gets more
    // than DEPTH ahead, which the extra pointer bit disambiguates.
    ram_cnt = wbin - rbin_d;
    // Comparing in Gray avoids depending on the decoded value for empty.
    ram_empty_d       = (rdptr_d == q2_wptr);
    rd_count_d        = ram_cnt + (AW+1)'(held_next);
    rd_almost_empty_d = (rd_count_d <= AE_TH_W);
    rd_underflow_d    = rd_underflow_q | rd_reject;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q            <= '0;
      rdptr_q           <= '0;
      ram_empty_q       <= 1'b1;
      rd_almost_empty_q <= 1'b1;
      rd_count_q        <= '0;
      rd_underflow_q    <= 1'b0;
    end else begin
      rbin_q            <= rbin_d;
      rdptr_q           <= rdptr_d;
      ram_empty_q       <= ram_empty_d;
      rd_almost_empty_q <= rd_almost_empty_d;
      rd_count_q        <= rd_count_d;
      rd_underflow_q    <= rd_underflow_d;
    end
  end

  assign rdptr           = rdptr_q;
  assign raddr           = rbin_q[AW-1:0];
  assign rd_almost_empty = rd_almost_empty_q;
  assign rd_count        = rd_count_q;
  assign rd_underflow    = rd_underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

  import pkg_graybin::*;

  localparam int D     = 16;
  localparam int WD    = 8;
  localparam int AE    = 2;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rden = 1'b0;
  ptr_t          q2_wptr = '0;
  logic [WD-1:0] mem_rdata;
  ptr_t          rdptr;
  addr_t         raddr;
  logic          rd_empty, rd_almost_empty, rd_underflow, dout_valid;
  ptr_t          rd_count;
  logic [WD-1:0] dout;

  logic [WD-1:0] mem [D];
  assign mem_rdata = mem[raddr];

  always #5 rclk = ~rclk;

  fifo_rd_ctrl #(.DEPTH(D), .WIDTH(WD), .AE_TH(AE)) dut (
    .rclk            (rclk),
    .rrst            (rrst),
    .rden            (rden),
    .q2_wptr         (q2_wptr),
    .mem_rdata       (mem_rdata),
    .rdptr           (rdptr),
    .raddr           (raddr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_count        (rd_count),
    .rd_underflow    (rd_underflow),
    .dout            (dout),
    .dout_valid      (dout_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of words written and popped since reset, plus
  // the list of written data in order.
  int            wr_n = 0;
  int            rd_n = 0;
  logic [WD-1:0] wdata_q [$];
  bit            m_empty = 1, m_ae = 1, m_uf = 0, m_dv = 0, m_ram_empty = 1;
  int            m_cnt = 0;
  logic [WD-1:0] m_dout = '0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic model_step(input bit rd, input bit rst);
    if (rst) begin
      rd_n = 0; m_empty = 1; m_ae = 1; m_uf = 0; m_cnt = 0; m_dv = 0; m_ram_empty = 1;
      return;
    end
`ifdef FIFO_RD_FWFT_EN
    if (rd && !m_dv) m_uf = 1;
    if (!m_ram_empty && (!m_dv || rd)) begin
      m_dout = wdata_q[rd_n];
      m_dv   = 1;
      rd_n++;
    end else if (rd) begin
      m_dv = 0;
    end
    m_ram_empty = (wr_n == rd_n);
    m_cnt       = wr_n - rd_n + int'(m_dv);
    m_empty     = !m_dv;
`else
    if (rd && m_empty) m_uf = 1;
    if (rd && !m_empty) rd_n++;
    m_cnt   = wr_n - rd_n;
    m_empty = (m_cnt == 0);
    m_dv    = !m_empty;
    if (m_dv) m_dout = wdata_q[rd_n];
`endif
    m_ae = (m_cnt <= AE);
  endtask

  function automatic int occupancy();
`ifdef FIFO_RD_FWFT_EN
    return wr_n - rd_n + int'(m_dv);
`else
    return wr_n - rd_n;
`endif
  endfunction

  task automatic check_all();
    check_eq("rd_empty", 32'(rd_empty), 32'(m_empty));
    check_eq("rd_almost_empty", 32'(rd_almost_empty), 32'(m_ae));
    check_eq("rd_count", 32'(rd_count), m_cnt);
    check_eq("rd_underflow", 32'(rd_underflow), 32'(m_uf));
    check_eq("rdptr", 32'(rdptr), gray(rd_n % (2*D)));
    check_eq("raddr", 32'(raddr), rd_n % D);
    check_eq("dout_valid", 32'(dout_valid), 32'(m_dv));
    if (m_dv) check_eq("dout", 32'(dout), 32'(m_dout));
  endtask

  // One rclk cycle: inputs change at negedge, outputs checked 1 after posedge.
  // A write lands in the RAM and the synchronised pointer together.
  task automatic cycle(input bit rd, input bit wr, input bit rst, input int wd = -1);
    logic [WD-1:0] d;
    @(negedge rclk);
    rrst = rst;
    rden = rd;
    if (rst) begin
      wr_n = 0;
      wdata_q.delete();
    end else if (wr && occupancy() < D) begin
      d = (wd < 0) ? WD'($urandom) : WD'(wd);
      mem[wr_n % D] = d;
      wdata_q.push_back(d);
      wr_n++;
    end
    q2_wptr = ptr_t'(gray(wr_n % (2*D)));
    @(posedge rclk);
    model_step(rd, rst);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = '0;

    cycle(0, 0, 1);
    cycle(0, 0, 1);
    check_eq("rst_empty", 32'(rd_empty), 1);
    check_eq("rst_count", 32'(rd_count), 0);

    // Reads against an empty FIFO.
    cycle(1, 0, 0);
    check_eq("t1_underflow", 32'(rd_underflow), 1);
    check_eq("t1_raddr", 32'(raddr), 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_eq("t1_empty", 32'(rd_empty), 1);
    cycle(0, 0, 1);
    check_eq("t1_underflow_clr", 32'(rd_underflow), 0);

`ifndef FIFO_RD_FWFT_EN
    // Five words then drain one per cycle.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    check_eq("t2_count5", 32'(rd_count), 5);
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 0);
      check_eq("t2_count", 32'(rd_count), 5 - i);
      check_eq("t2_ae", 32'(rd_almost_empty), (5 - i) <= 2 ? 1 : 0);
      check_eq("t2_empty", 32'(rd_empty), (i == 5) ? 1 : 0);
    end
    cycle(0, 0, 1);

    // Pop plus write every cycle at count 1, through a pointer wrap.
    cycle(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0);
      check_eq("t3_rdptr", 32'(rdptr), gray((i + 1) % 32));
      check_eq("t3_empty", 32'(rd_empty), 0);
      check_eq("t3_count", 32'(rd_count), 1);
      check_eq("t3_underflow", 32'(rd_underflow), 0);
    end
    cycle(0, 0, 1);
`else
    // First word falls through without a read request.
    cycle(0, 1, 0, 8'hA5);
    cycle(0, 0, 0);
    check_eq("t6_dout", 32'(dout), 32'h A5);
    check_eq("t6_valid", 32'(dout_valid), 1);
    check_eq("t6_empty", 32'(rd_empty), 0);
    cycle(1, 0, 0);
    check_eq("t6_valid_drop", 32'(dout_valid), 0);
    check_eq("t6_empty_set", 32'(rd_empty), 1);
    cycle(0, 0, 1);
`endif

    // Reset in the middle of a stream.
    for (int i = 0; i < 7; i++) cycle(0, 1, 0);
    check_eq("t5_count7", 32'(rd_count), 7);
    cycle(0, 0, 1);
    check_eq("t5_rdptr", 32'(rdptr), 0);
    check_eq("t5_count", 32'(rd_count), 0);
    check_eq("t5_empty", 32'(rd_empty), 1);
    check_eq("t5_valid", 32'(dout_valid), 0);

    // Random traffic in phases biased towards fill, drain and balance.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 120; i++) begin
        int wr_pct;
        int rd_pct;
        wr_pct = (p % 3 == 0) ? 85 : (p % 3 == 1) ? 20 : 50;
        rd_pct = (p % 3 == 0) ? 25 : (p % 3 == 1) ? 85 : 50;
        cycle($urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < wr_pct,
              $urandom_range(0, 249) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
